// File: rtl/sync_ram_be_clr.sv
// sync_ram_be_clr
// Single-clock simple dual-port RAM (one write port, one read port) with
// per-byte write enables, selectable read-during-write behaviour, optional
// output register and a hardware clear engine that zeroes the whole array.
//
// Ports
//   clk        clock, rising edge
//   reset_n    asynchronous active-low reset (array contents untouched)
//   clr_start  pulse: start a full-array clear when idle
//   busy       high while the clear engine runs
//   we/be      write enable / per-lane byte enables
//   waddr/d    write address / write data
//   re/raddr   read enable / read address
//   q/q_valid  read data / valid flag, 1 + OUT_REG cycles after re
module sync_ram_be_clr #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned BYTE_WIDTH   = 8,
  parameter int unsigned RDW_MODE     = 0,
  parameter int unsigned OUT_REG      = 0,
  parameter int unsigned CLR_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clr_start,
  output logic                             busy,
  input  logic                             we,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            d,
  input  logic                             re,
  input  logic [ADDR_WIDTH-1:0]            raddr,
  output logic [DATA_WIDTH-1:0]            q,
  output logic                             q_valid
);

  localparam int unsigned NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   cnt, cnt_next;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    wr_en;
  logic                    rd_en;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   r1;
  logic                    v1;

  // User accesses are only accepted while the clear engine is idle.
  assign wr_en = (state == IDLE) && we;
  assign rd_en = (state == IDLE) && re;
  assign busy  = (state == CLEAR);

  // Clear engine FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      if (CLR_ON_RESET == 1) state <= CLEAR;
      else                   state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        // Counter wraps to 0 on the final address, leaving it ready for
        // the next clear.
        cnt_next = cnt + 1'b1;
        if (cnt == '1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Array write port: clear engine has priority; array is never reset.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) mem[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= d[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Read word. The registered read below samples the array before the
  // same-edge write lands, which gives old-data behaviour for free; in
  // new-data mode the enabled lanes are bypassed from d.
  always_comb begin
    rd_word = mem[raddr];
    if (RDW_MODE == 1 && wr_en && (waddr == raddr)) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) rd_word[i*BYTE_WIDTH +: BYTE_WIDTH] = d[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // First read stage: data only updates on an accepted read so q holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rd_en;
      if (rd_en) r1 <= rd_word;
    end
  end

  if (OUT_REG == 1) begin : g_oreg
    logic [DATA_WIDTH-1:0] r2;
    logic                  v2;

    // In-flight reads drain through here even while clearing.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r2 <= '0;
        v2 <= 1'b0;
      end else begin
        v2 <= v1;
        if (v1) r2 <= r1;
      end
    end

    assign q       = r2;
    assign q_valid = v2;
  end else begin : g_noreg
    assign q       = r1;
    assign q_valid = v1;
  end

endmodule

// File: doc/sync_ram_be_clr.md
Name: sync_ram_be_clr

Overview:
- Parametrised single-clock simple dual-port RAM: one write port, one read port.
- Next generation of the team's one-port block RAM.
- Adds per-byte write enables, a selectable read-during-write mode, an optional output pipeline register, a read-valid flag and a hardware clear engine that zeroes the array after reset or on request.
- Used as the buffer memory behind FIFOs, line buffers and register files in the FPGA datapath.

Parameters:
- DATA_WIDTH, 32: word width in bits; must be an integer multiple of BYTE_WIDTH.
- ADDR_WIDTH, 10: address bits; depth = 2**ADDR_WIDTH.
- BYTE_WIDTH, 8: bits per byte-enable lane; NB = DATA_WIDTH/BYTE_WIDTH.
- RDW_MODE, 0: same-address read-during-write. 0 = old data, 1 = new (merged) data.
- OUT_REG, 0: 0 = read latency 1; 1 = extra output register, latency 2.
- CLR_ON_RESET, 1: 1 = run the clear engine automatically after reset release.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- clr_start, input, 1: pulse; starts a full-array clear when idle.
- busy, output, 1: high while the clear engine runs.
- we, input, 1: write enable.
- be, input, NB: byte enables; bit i selects d[i*BYTE_WIDTH +: BYTE_WIDTH].
- waddr, input, ADDR_WIDTH: write address.
- d, input, DATA_WIDTH: write data.
- re, input, 1: read enable.
- raddr, input, ADDR_WIDTH: read address.
- q, output, DATA_WIDTH: read data.
- q_valid, output, 1: q holds the data for a read issued LAT cycles earlier.

Behaviour:
- Reset (reset_n low, asynchronous):
  - q=0, q_valid=0, internal pipeline valid=0.
  - Clear counter=0.
  - State=CLEAR if CLR_ON_RESET=1 (busy=1 during and after reset), else IDLE (busy=0).
  - Array contents are not reset by reset_n; they are zeroed only by the clear engine.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clr_start=1; counter loads 0.
  - CLEAR: each cycle writes all-zero to array[counter] and increments the counter.
  - When counter = 2**ADDR_WIDTH-1, the final zero write occurs, counter wraps to 0 and state -> IDLE. busy is low from the next cycle.
  - A clear takes exactly 2**ADDR_WIDTH cycles.
- In CLEAR:
  - we and re are ignored: no user write, no new read.
  - clr_start is ignored.
  - Reads already in flight in the OUT_REG pipeline still complete with their original data and q_valid.
- Write (IDLE, we=1): on the clock edge, each lane with be[i]=1 is written from d; lanes with be[i]=0 keep their value. be=0 with we=1 is a no-op.
- Read (IDLE, re=1):
  - LAT = 1 + OUT_REG.
  - array[raddr] appears on q, with q_valid=1, LAT cycles after the cycle re was sampled.
  - q_valid=1 exactly one cycle per accepted read.
  - When no read completes, q holds its last value and q_valid=0.
- Same-address read and write in the same cycle:
  - RDW_MODE=0: q returns the pre-write word.
  - RDW_MODE=1: q returns the merged word (enabled lanes from d, other lanes the old value).
  - Different addresses: no interaction.
- clr_start together with we/re in IDLE: the write and read that cycle are honoured, and the clear starts on the following cycle. The written word is later zeroed.
- Back-to-back reads every cycle are supported at full throughput.
- Reset mid-clear: the clear aborts immediately. If CLR_ON_RESET=1, it restarts from address 0 after reset release; otherwise the array is left partially cleared and state is IDLE.
- No address range checks are needed; all ADDR_WIDTH values are legal.

Test Plan:
1. ADDR_WIDTH=4, CLR_ON_RESET=1: release reset_n.
   - busy=1 for exactly 16 cycles, then 0.
   - Reads of addresses 0..15 return 0x00000000 with q_valid 1 cycle after re.
2. Write 0xAABBCCDD to address 5 with be=4'b1111, then 0x11223344 with be=4'b0101.
   - Read of address 5 returns 0xAA22CC44.
3. Same-cycle write of 0x12345678 and read of address 3, whose old value is 0xDEADBEEF:
   - RDW_MODE=0: q=0xDEADBEEF.
   - RDW_MODE=1: q=0x12345678.
4. OUT_REG=1: reads of addresses 1, 2, 3 on consecutive cycles.
   - q_valid high on cycles +2, +3, +4 with the matching data.
   - q is held and q_valid=0 afterwards.
5. Mid-operation clear: fill the array with nonzero data, pulse clr_start together with a write of 0xFFFFFFFF to address 7.
   - busy rises next cycle.
   - we/re during busy have no effect.
   - After 16 cycles, all addresses including 7 read 0.
6. Assert reset_n low at clear counter=9:
   - busy stays 1 through reset, q=0, q_valid=0.
   - The clear restarts from address 0 and busy lasts 16 cycles after release.
